// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, types and symbol function for the K=4 rate-1/2 code
// Used by the encoder and by the Viterbi decoder so both sides agree on taps and state order.
package conv_pkg;
    localparam int K = 4;
    localparam int NSTATE = 8;
    localparam int TAIL_LEN = 3;
    localparam logic [3:0] G0_DEF = 4'b1111;
    localparam logic [3:0] G1_DEF = 4'b1101;
    typedef enum logic [1:0] {IDLE, DATA, FLUSH} enc_state_t;
    typedef logic [2:0] trellis_state_t;
    // Tap vector is {b, st[2], st[1], st[0]}; result is {c1, c0}.
    function automatic logic [1:0] conv_sym(input logic b, input trellis_state_t st,
                                            input logic [3:0] g0, input logic [3:0] g1);
        logic [3:0] v;
        v = {b, st};
        return {^(v & g1), ^(v & g0)};
    endfunction
endpackage

// File: rtl/conv_enc_core.sv
// conv_enc_core: combinational trellis step, symbol and next state for one input bit
// Ports: b (input bit), st (current state), sym ({c1,c0}), st_next ({b, st[2:1]}).
module conv_enc_core
    import conv_pkg::*;
#(
    parameter logic [3:0] G0 = G0_DEF,
    parameter logic [3:0] G1 = G1_DEF
) (
    input  logic           b,
    input  trellis_state_t st,
    output logic [1:0]     sym,
    output trellis_state_t st_next
);
    assign sym = conv_sym(b, st, G0, G1);
    // Newest bit enters at the top so the decoder's predecessor {s[1:0], d} inverts this step.
    assign st_next = {b, st[2:1]};
endmodule

// File: rtl/conv_encoder.sv
// conv_encoder: framed rate-1/2 K=4 convolutional encoder with 3-symbol zero tail
// Ports: clk, rst (async, active-high), enable (freezes everything when low),
//        in_valid/in_ready/in_data/in_last (bit input), out_valid/out_ready/out_sym/out_last
//        (symbol output, out_sym = {c1,c0}), out_mask (only with CONV_ENC_PUNCTURE_EN).
// Optional: CONV_ENC_PUNCTURE_EN adds a rate-2/3 puncturing mask alongside each symbol.
module conv_encoder
    import conv_pkg::*;
#(
    parameter logic [3:0] G0 = G0_DEF,
    parameter logic [3:0] G1 = G1_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_data,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_sym,
    output logic       out_last
`ifdef CONV_ENC_PUNCTURE_EN
    ,
    output logic [1:0] out_mask
`endif
);
    enc_state_t     state, state_next;
    trellis_state_t st, st_next;
    logic [1:0]     tail_cnt, sym;
    logic           slot_free, flushing, accept, load, tail_end, b;

    assign slot_free = !out_valid || out_ready;
    assign flushing  = state == FLUSH;
    assign accept    = in_valid && in_ready;
    // A flush step shares the output slot with accepted bits; both need enable and a free slot.
    assign load      = accept || (enable && slot_free && flushing);
    assign tail_end  = flushing && tail_cnt == 2'(TAIL_LEN - 1);
    assign b         = !flushing && in_data;

    conv_enc_core #(.G0(G0), .G1(G1)) u_core (
        .b       (b),
        .st      (st),
        .sym     (sym),
        .st_next (st_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else if (enable)
            state <= state_next;
    end

    always_comb begin
        state_next = (accept && in_last)              ? FLUSH :
                     (accept && state == IDLE)        ? DATA  :
                     (load && tail_end)               ? IDLE  : state;
    end

    always_comb begin
        in_ready = enable && slot_free && !flushing;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= '0;
            tail_cnt  <= '0;
            out_valid <= 1'b0;
            out_sym   <= '0;
            out_last  <= 1'b0;
        end else if (enable) begin
            if (load) begin
                st        <= st_next;
                out_valid <= 1'b1;
                out_sym   <= sym;
                out_last  <= tail_end;
                tail_cnt  <= (flushing && !tail_end) ? tail_cnt + 2'd1 : 2'd0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef CONV_ENC_PUNCTURE_EN
    // odd tracks the parity of the next information bit's index within the frame.
    logic       odd;
    logic [1:0] mask;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            odd  <= 1'b0;
            mask <= 2'b11;
        end else if (load) begin
            mask <= (accept && state == DATA && odd) ? 2'b01 : 2'b11;
            odd  <= accept && (state == IDLE || !odd);
        end
    end
    assign out_mask = out_valid ? mask : 2'b00;
`endif
endmodule
